// File: rtl/equiv_mismatch_monitor.sv
// equiv_mismatch_monitor
// Compares the paired outputs of two design instances on every enabled clock,
// ignores a warm-up window after reset, captures the first divergence
// (cycle index and XOR signature) and keeps a saturating count of divergences.
module equiv_mismatch_monitor #(
  parameter int WIDTH  = 91,
  parameter int WARMUP = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] y_1,
  input  logic [WIDTH-1:0] y_2,
  output logic             fail,
  output logic [CNT_W-1:0] first_cycle,
  output logic [WIDTH-1:0] first_diff,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_CHECK  = 2'd1,
    ST_FAIL   = 2'd2
  } state_t;

  // A zero-length warm-up still needs a legal one-bit counter.
  localparam int WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam state_t RST_STATE = (WARMUP == 0) ? ST_CHECK : ST_WARMUP;

  // Saturating increment shared by the cycle and mismatch counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               fail_q, fail_d;
  logic [CNT_W-1:0]   first_cycle_q, first_cycle_d;
  logic [WIDTH-1:0]   first_diff_q, first_diff_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               mis;

  assign mis = en && (y_1 != y_2);

  // Next-state and capture logic; everything holds while en is low.
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    fail_d        = fail_q;
    first_cycle_d = first_cycle_q;
    first_diff_d  = first_diff_q;
    miss_cnt_d    = miss_cnt_q;
    cycle_cnt_d   = cycle_cnt_q;

    if (en) begin
      cycle_cnt_d = sat_inc(cycle_cnt_q);
    end

    case (state_q)
      ST_WARMUP: begin
        // The sample on the leaving edge is still part of the warm-up.
        if (en) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
          if (wcnt_q == WLAST) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (mis) begin
          fail_d        = 1'b1;
          first_cycle_d = cycle_cnt_q;
          first_diff_d  = y_1 ^ y_2;
          miss_cnt_d    = CNT_W'(1);
          state_d       = ST_FAIL;
        end
      end
      ST_FAIL: begin
        // Terminal: only the mismatch count moves, first_* stay frozen.
        if (mis) begin
          miss_cnt_d = sat_inc(miss_cnt_q);
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // State and capture registers; reset overrides en and mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RST_STATE;
      wcnt_q        <= '0;
      fail_q        <= 1'b0;
      first_cycle_q <= '0;
      first_diff_q  <= '0;
      miss_cnt_q    <= '0;
      cycle_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      fail_q        <= fail_d;
      first_cycle_q <= first_cycle_d;
      first_diff_q  <= first_diff_d;
      miss_cnt_q    <= miss_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  assign fail        = fail_q;
  assign first_cycle = first_cycle_q;
  assign first_diff  = first_diff_q;
  assign miss_cnt    = miss_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign state       = state_q;

endmodule
